// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake bundle for the icache_sa instruction cache.
// The slave modport is the cache; the master modport is the fetch stage plus refill bus.
interface icache_sa_if #(
  parameter int ADDR_WD    = 32,
  parameter int LINE_WORDS = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_WD-1:0]       req_addr;
  logic                     resp_valid;
  logic [LINE_WORDS*32-1:0] resp_data;
  logic                     flush;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_WD-1:0]       mem_req_addr;
  logic                     mem_rsp_valid;
  logic [31:0]              mem_rsp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_sa.sv
// Blocking read-only set-associative L1 instruction cache returning whole lines.
// Define ICACHE_PERF_EN to add the hit_cnt / miss_cnt performance counters.
module icache_sa #(
  parameter int ADDR_WD    = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  icache_sa_if.slave  bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_WD  = $clog2(LINE_WORDS * 4);
  localparam int IDX_WD  = $clog2(SETS);
  localparam int TAG_WD  = ADDR_WD - IDX_WD - OFF_WD;
  localparam int LA_WD   = ADDR_WD - OFF_WD;
  localparam int WAY_WD  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_WD = $clog2(LINE_WORDS);
  localparam int LINE_WD = LINE_WORDS * 32;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, REFILL, RESP} state_t;

  state_t              state_q, state_d;
  logic [LA_WD-1:0]    addr_q, addr_d;
  logic [BEAT_WD-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_WD-1:0]  line_q, line_d;
  logic                flush_pend_q, flush_pend_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [WAY_WD-1:0]   rr_ptr_q [SETS];
  logic [WAY_WD-1:0]   rr_ptr_d [SETS];

  logic [IDX_WD-1:0]   cur_idx;
  logic [TAG_WD-1:0]   cur_tag;
  logic [IDX_WD-1:0]   req_idx;
  logic                ready_c;
  logic                accept;
  logic [WAYS-1:0]     hit_vec;
  logic                hit;
  logic [LINE_WD-1:0]  hit_line;
  logic [WAY_WD-1:0]   victim;
  logic                all_valid;
  logic [WAYS-1:0]     way_we;
  logic [WAYS-1:0][TAG_WD-1:0]  way_tag;
  logic [WAYS-1:0][LINE_WD-1:0] way_data;

  logic                resp_valid_c;
  logic [LINE_WD-1:0]  resp_data_c;
  logic                mem_req_valid_c;
  logic [ADDR_WD-1:0]  mem_req_addr_c;

  assign cur_idx = addr_q[IDX_WD-1:0];
  assign cur_tag = addr_q[IDX_WD +: TAG_WD];
  assign req_idx = bus.req_addr[OFF_WD +: IDX_WD];

  // A new request can be taken while idle or alongside a hit response.
  assign ready_c = !rst && ((state_q == IDLE) || (state_q == LOOKUP && hit));
  assign accept  = bus.req_valid && ready_c;

  // Per-way tag/data RAMs: read on acceptance so the lookup cycle sees registered data.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_WD-1:0]  tag_mem  [SETS];
      logic [LINE_WD-1:0] data_mem [SETS];
      logic [TAG_WD-1:0]  rd_tag_q;
      logic [LINE_WD-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (way_we[gi]) begin
          tag_mem[cur_idx]  <= cur_tag;
          data_mem[cur_idx] <= line_q;
        end
        if (accept) begin
          rd_tag_q  <= tag_mem[req_idx];
          rd_data_q <= data_mem[req_idx];
        end
      end

      assign way_tag[gi]  = rd_tag_q;
      assign way_data[gi] = rd_data_q;
      assign hit_vec[gi]  = valid_q[cur_idx][gi] && (rd_tag_q == cur_tag);
    end
  endgenerate

  assign hit       = |hit_vec;
  assign all_valid = &valid_q[cur_idx];

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_line = hit_line | (hit_vec[w] ? way_data[w] : '0);
    end
  end

  // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr_ptr_q[cur_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[cur_idx][w]) begin
        victim = WAY_WD'(w);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_cnt_d      = beat_cnt_q;
    line_d          = line_q;
    flush_pend_d    = flush_pend_q;
    valid_d         = valid_q;
    rr_ptr_d        = rr_ptr_q;
    way_we          = '0;
    resp_valid_c    = 1'b0;
    resp_data_c     = '0;
    mem_req_valid_c = 1'b0;
    mem_req_addr_c  = '0;

    if (!rst) begin
      if (accept) begin
        addr_d = bus.req_addr[ADDR_WD-1:OFF_WD];
      end

      case (state_q)
        IDLE: begin
          if (accept) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_c = 1'b1;
            resp_data_c  = hit_line;
            state_d      = accept ? LOOKUP : IDLE;
          end else begin
            state_d = MEM_REQ;
          end
        end
        MEM_REQ: begin
          mem_req_valid_c = 1'b1;
          mem_req_addr_c  = {addr_q, {OFF_WD{1'b0}}};
          if (bus.mem_req_ready) begin
            state_d    = REFILL;
            beat_cnt_d = '0;
          end
        end
        REFILL: begin
          if (bus.mem_rsp_valid) begin
            line_d[{beat_cnt_q, 5'd0} +: 32] = bus.mem_rsp_data;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == BEAT_WD'(LINE_WORDS - 1)) state_d = RESP;
          end
        end
        RESP: begin
          resp_valid_c = 1'b1;
          resp_data_c  = line_q;
          if (!flush_pend_q) begin
            way_we[victim]           = 1'b1;
            valid_d[cur_idx][victim] = 1'b1;
            if (all_valid) begin
              rr_ptr_d[cur_idx] = (rr_ptr_q[cur_idx] == WAY_WD'(WAYS - 1)) ?
                                  '0 : rr_ptr_q[cur_idx] + 1'b1;
            end
          end
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Flush overrides any install in the same cycle; an in-flight refill is marked not to install.
      if (bus.flush) begin
        for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        if (state_q == MEM_REQ || state_q == REFILL) flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '{default: '0};
      rr_ptr_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.resp_valid    = resp_valid_c;
  assign bus.resp_data     = resp_data_c;
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_req_addr  = mem_req_addr_c;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (!rst && state_q == LOOKUP) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised, blocking, read-only set-associative L1 instruction cache between the fetch stage and the memory bus.
- Generalises the fixed 4-way / 256-set / 16 B-line layout to configurable ways, sets and line size.
- Adds:
  - a refill state machine,
  - invalid-first plus per-set round-robin replacement,
  - a one-cycle whole-cache flush.
- Returns the whole line, LINE_WORDS instructions, containing the requested address.

Parameters:
- ADDR_WD, 32, address width.
- WAYS, 4, associativity; power of two, ≥1.
- SETS, 256, number of sets; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.
- Derived:
  - OFF_WD = log2(LINE_WORDS*4)
  - IDX_WD = log2(SETS)
  - TAG_WD = ADDR_WD-IDX_WD-OFF_WD
  - defaults give 4/8/20.

Ports:
- clk  in  1  clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_addr  in  ADDR_WD  fetch byte address; offset bits ignored.
- resp_valid  out  1  one-cycle pulse; line on resp_data. No back-pressure.
- resp_data  out  LINE_WORDS*32  line; word i at bits [32i+31:32i].
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  bus accepts refill request.
- mem_req_addr  out  ADDR_WD  line-aligned refill address (offset bits zero).
- mem_rsp_valid  in  1  refill beat valid.
- mem_rsp_data  in  32  refill beat, word 0 first.

Behaviour:
- Storage:
  - Valid bits in flops, WAYS×SETS, cleared by reset and flush.
  - Tag/data arrays not reset.
  - rr_ptr per set, log2(WAYS) bits, reset to 0.
- Request address is latched on acceptance into addr_q.
- FSM states: IDLE, LOOKUP, MEM_REQ, REFILL, RESP. Reset → IDLE.
- Reset values: req_ready=0 during reset, resp_valid=0, mem_req_valid=0, resp_data=0, mem_req_addr=0.
- IDLE:
  - req_ready=1.
  - On accept → LOOKUP.
- LOOKUP:
  - Compare addr_q tag against all valid ways of set addr_q index.
  - Hit (exactly one way): resp_valid=1 with that way's line this cycle.
    - req_ready=1, so a new request may be accepted in the same cycle (back-to-back hits, one per cycle).
    - → LOOKUP if accepted, else IDLE.
  - Miss: req_ready=0 → MEM_REQ.
  - Hit latency: resp 1 cycle after acceptance.
- MEM_REQ:
  - mem_req_valid=1, mem_req_addr={tag,index,0}, held stable until mem_req_ready.
  - Then → REFILL with beat_cnt=0.
- REFILL:
  - Each mem_rsp_valid writes mem_rsp_data into line buffer word beat_cnt; beat_cnt++.
  - On beat LINE_WORDS-1 → RESP.
  - Beats may have gaps of any length.
- RESP:
  - resp_valid=1, resp_data=line buffer.
  - Line installed into the victim way this cycle (tag, data, valid=1) unless flush_pend.
  - → IDLE. req_ready=0 in RESP.
- Victim selection:
  - Lowest-index invalid way if any.
  - Otherwise way rr_ptr[index]; rr_ptr[index] increments, mod WAYS, only when an all-valid set is replaced.
- Flush:
  - Clears all valid bits the cycle after assertion, in any state.
  - If asserted in MEM_REQ or REFILL, sets flush_pend: the in-flight line is still returned but not installed. flush_pend clears in RESP.
  - Flush in the same cycle as a LOOKUP hit: the hit response is still delivered.
- Reset mid-refill:
  - FSM → IDLE; beat_cnt and flush_pend cleared.
  - Stray mem_rsp_valid beats outside REFILL are ignored.
- Miss latency with zero-wait bus: 1 (LOOKUP) + 1 (MEM_REQ) + LINE_WORDS beats + 1 (RESP) = LINE_WORDS+3 cycles after acceptance.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP miss.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, request 0x0000_1008; bus returns 0x11,0x22,0x33,0x44 with zero wait.
  - Response: mem_req_addr=0x0000_1000; resp_valid 7 cycles after acceptance; resp_data={0x44,0x33,0x22,0x11}.
- Back-to-back hits:
  - Stimulus: after the cold miss, req_valid held with 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Response: three consecutive resp_valid pulses with the same line; no mem_req_valid.
- Replacement:
  - Stimulus: fill set 0 with tags for 0x00000, 0x01000, 0x02000, 0x03000 (ways 0-3), then miss 0x04000.
  - Response: way 0 replaced, rr_ptr[0]=1; re-request 0x00000 misses; 0x01000 hits.
- Flush during refill:
  - Stimulus: miss 0x2000, assert flush at beat 2.
  - Response: resp still returns the line; a re-request of 0x2000 misses again; all previously valid lines miss.
- Reset mid-refill:
  - Stimulus: assert rst after beat 1, then send 2 stray beats.
  - Response: FSM in IDLE, mem_req_valid=0, no resp_valid; the next request to the same line is a clean miss.
- ICACHE_PERF_EN:
  - Stimulus: run the cold-miss and back-to-back-hits scenarios.
  - Response: miss_cnt=1, hit_cnt=3.
